// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use/branch stall, branch/jump flush control with optional stats (HAZARD_STATS_EN).
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        ID_EX_reg_write,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  ID_EX_dst,
  input  logic        EX_MEM_mem_read,
  input  logic [4:0]  EX_MEM_dst,
  input  logic        regs_equal,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        pc_src,
  output logic        pc_jump,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  logic [0:0] state_q, state_d;
  logic       cnt_q, cnt_d;
  logic       is_r, is_j, is_beq, is_bne, is_sw, branch, uses_rt;
  logic       m_idex, m_exmem, n2, n1, stall, take;
  assign is_r    = opcode == 6'b000000;
  assign is_j    = opcode == 6'b000010;
  assign is_beq  = opcode == 6'b000100;
  assign is_bne  = opcode == 6'b000101;
  assign is_sw   = opcode == 6'b101011;
  assign branch  = is_beq | is_bne;
  assign uses_rt = is_r | branch | is_sw;
  assign m_idex  = (ID_EX_dst != 5'd0) && (ID_EX_dst == IF_ID_rs || (uses_rt && ID_EX_dst == IF_ID_rt));
  assign m_exmem = (EX_MEM_dst != 5'd0) && (EX_MEM_dst == IF_ID_rs || (uses_rt && EX_MEM_dst == IF_ID_rt));
  assign n2 = branch & ID_EX_mem_read & m_idex;
  assign n1 = (branch & ID_EX_reg_write & m_idex) | (branch & EX_MEM_mem_read & m_exmem) |
              (~branch & ID_EX_mem_read & m_idex);
  // STALL state forces a stall regardless of the current hazard decode
  assign stall        = (state_q == STALL) | n2 | n1;
  assign take         = ~stall & ((is_beq & regs_equal) | (is_bne & ~regs_equal));
  assign pc_write     = ~stall;
  assign IF_ID_write  = ~stall;
  assign ID_EX_bubble = stall;
  assign pc_src       = take;
  assign pc_jump      = ~stall & is_j;
  assign IF_ID_flush  = take | (~stall & is_j);
  always_comb begin
    state_d = (state_q == STALL) ? (cnt_q ? RUN : STALL) : (n2 ? STALL : RUN);
    cnt_d   = (state_q == STALL) ? cnt_q - 1'b1 : n2;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_q + {15'd0, ID_EX_bubble & ~&stall_q};
      flush_q <= flush_q + {15'd0, IF_ID_flush & ~&flush_q};
    end
  end
  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = 16'd0;
  assign flush_count = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed stimulus checked every cycle against a rule-level model plus literal expectations.
module tb_hazard_control_unit;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic [4:0] rs = 5'd0, rt = 5'd0, idst = 5'd0, edst = 5'd0;
  logic irw = 1'b0, imr = 1'b0, emr = 1'b0, eq = 1'b0;
  logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pc_src, pc_jump;
  logic [15:0] stall_count, flush_count;
  int total = 0, bad = 0;
  int rem = 0, sc = 0, fc = 0;
  always #5 clk = ~clk;
  hazard_control_unit dut (
    .clk(clk), .rst(rst), .opcode(op), .IF_ID_rs(rs), .IF_ID_rt(rt),
    .ID_EX_reg_write(irw), .ID_EX_mem_read(imr), .ID_EX_dst(idst),
    .EX_MEM_mem_read(emr), .EX_MEM_dst(edst), .regs_equal(eq),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .pc_src(pc_src), .pc_jump(pc_jump),
    .stall_count(stall_count), .flush_count(flush_count));
  function automatic bit dep(input logic [4:0] d);
    bit urt;
    urt = op == 6'd0 || op == 6'd4 || op == 6'd5 || op == 6'h2b;
    return d != 5'd0 && (d == rs || (urt && d == rt));
  endfunction
  function automatic int model_n();
    bit br;
    int n;
    br = op == 6'd4 || op == 6'd5;
    n = 0;
    if (br && imr && dep(idst)) n = 2;
    if (br && irw && dep(idst) && n < 1) n = 1;
    if (br && emr && dep(edst) && n < 1) n = 1;
    if (!br && imr && dep(idst) && n < 1) n = 1;
    return n;
  endfunction
  // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pc_src, pc_jump}
  function automatic logic [5:0] model_o();
    bit s, tk, jp;
    s  = rem > 0 || model_n() > 0;
    tk = !s && ((op == 6'd4 && eq) || (op == 6'd5 && !eq));
    jp = !s && op == 6'd2;
    return {!s, !s, tk || jp, s, tk, jp};
  endfunction
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst) begin
    logic [5:0] e;
    if (!rst) begin
      rem = 0; sc = 0; fc = 0;
    end else begin
      e = model_o();
      if (e[2] && sc < 65535) sc++;
      if (e[3] && fc < 65535) fc++;
      if (rem > 0) rem--;
      else if (model_n() == 2) rem = 1;
    end
  end
  always @(negedge clk) begin
    logic [5:0] e;
    e = model_o();
    check("m_pc_write", pc_write, e[5]);
    check("m_IF_ID_write", IF_ID_write, e[4]);
    check("m_IF_ID_flush", IF_ID_flush, e[3]);
    check("m_ID_EX_bubble", ID_EX_bubble, e[2]);
    check("m_pc_src", pc_src, e[1]);
    check("m_pc_jump", pc_jump, e[0]);
    check("m_stall_count", stall_count, STATS ? sc[15:0] : 16'd0);
    check("m_flush_count", flush_count, STATS ? fc[15:0] : 16'd0);
  end
  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic rw,
                       input logic mr, input logic [4:0] d, input logic em, input logic [4:0] ed, input logic q);
    @(posedge clk);
    #1;
    op = o; rs = s; rt = t; irw = rw; imr = mr; idst = d; emr = em; edst = ed; eq = q;
    @(negedge clk);
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc_write", pc_write, 1);
    check("rst_bubble", ID_EX_bubble, 0);
    check("rst_stall_count", stall_count, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    // lw r5 in ID/EX, add rs=5
    drive(6'd0, 5'd5, 5'd6, 1, 1, 5'd5, 0, 5'd0, 0);
    check("lu_pc_write", pc_write, 0);
    check("lu_IF_ID_write", IF_ID_write, 0);
    check("lu_bubble", ID_EX_bubble, 1);
    drive(6'd0, 5'd5, 5'd6, 0, 0, 5'd0, 1, 5'd5, 0);
    check("lu_after_pc_write", pc_write, 1);
    // lw r7 then beq rs=7: RUN stall, STALL stall, then resolve
    drive(6'd4, 5'd7, 5'd8, 1, 1, 5'd7, 0, 5'd0, 1);
    check("br1_bubble", ID_EX_bubble, 1);
    check("br1_pc_src", pc_src, 0);
    drive(6'd4, 5'd7, 5'd8, 0, 0, 5'd0, 1, 5'd7, 1);
    check("br2_bubble", ID_EX_bubble, 1);
    drive(6'd4, 5'd7, 5'd8, 0, 0, 5'd0, 0, 5'd0, 1);
    check("br3_pc_src", pc_src, 1);
    check("br3_flush", IF_ID_flush, 1);
    check("br3_pc_write", pc_write, 1);
    // jump, untaken bne, taken bne
    drive(6'd2, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    check("j_pc_jump", pc_jump, 1);
    check("j_flush", IF_ID_flush, 1);
    check("j_pc_src", pc_src, 0);
    drive(6'd5, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 1);
    check("bne_nt_flush", IF_ID_flush, 0);
    check("bne_nt_pc_src", pc_src, 0);
    drive(6'd5, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0);
    check("bne_t_pc_src", pc_src, 1);
    // r0 destination, rt usage by lw vs sw, ALU producer before branch
    drive(6'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 5'd0, 0);
    check("r0_pc_write", pc_write, 1);
    drive(6'h23, 5'd1, 5'd9, 1, 1, 5'd9, 0, 5'd0, 0);
    check("lw_rt_nostall", pc_write, 1);
    drive(6'h2b, 5'd1, 5'd9, 1, 1, 5'd9, 0, 5'd0, 0);
    check("sw_rt_stall", ID_EX_bubble, 1);
    drive(6'd4, 5'd1, 5'd3, 1, 0, 5'd3, 0, 5'd0, 1);
    check("br_alu_bubble", ID_EX_bubble, 1);
    drive(6'd4, 5'd1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 1);
    check("br_alu_resolve", pc_src, 1);
    // reset in the middle of STALL abandons the stall
    drive(6'd4, 5'd7, 5'd8, 1, 1, 5'd7, 0, 5'd0, 1);
    drive(6'd4, 5'd7, 5'd8, 0, 0, 5'd0, 0, 5'd0, 1);
    check("stall_state_bubble", ID_EX_bubble, 1);
    #2 rst = 1'b0;
    #1 check("rst_mid_pc_write", pc_write, 1);
    check("rst_mid_pc_src", pc_src, 1);
    check("rst_mid_stall_count", stall_count, 0);
    drive(6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_pc_write", pc_write, 1);
    check("post_rst_flush_count", flush_count, 0);
    // statistics: 3 stalls then 2 flushes
    pulse_reset();
    repeat (3) drive(6'd0, 5'd4, 5'd0, 0, 1, 5'd4, 0, 5'd0, 0);
    repeat (2) drive(6'd2, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0);
    drive(6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0);
    check("stats_stall_count", stall_count, STATS ? 16'd3 : 16'd0);
    check("stats_flush_count", flush_count, STATS ? 16'd2 : 16'd0);
`ifdef HAZARD_STATS_EN
    drive(6'd0, 5'd4, 5'd0, 0, 1, 5'd4, 0, 5'd0, 0);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("stats_saturate", stall_count, 16'hFFFF);
`endif
    drive(6'd0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
